// File: rtl/cmsdk_irq_arb_pkg.sv
// Shared types and constants for the cmsdk_irq_arbiter slice.
// The FSM encodings are fixed so that the state can be observed on a debug bus.
package cmsdk_irq_arb_pkg;

  localparam int NUM_IRQ_MIN      = 2;
  localparam int NUM_IRQ_MAX      = 32;
  localparam int SYNC_FILL_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ASSERT = 2'b01,
    GAP    = 2'b10
  } arb_state_e;

  function automatic int id_width(input int num_irq);
    if (num_irq <= NUM_IRQ_MIN) return 1;
    if (num_irq > NUM_IRQ_MAX) return $clog2(NUM_IRQ_MAX);
    return $clog2(num_irq);
  endfunction

endpackage

// File: rtl/cmsdk_irq_arbiter_if.sv
// IRQ lines from the peripherals plus the request/acknowledge pair towards the core.
// master = arbiter side, slave = peripheral/core side.
interface cmsdk_irq_arbiter_if
  import cmsdk_irq_arb_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = id_width(NUM_IRQ)
);

  logic [NUM_IRQ-1:0] IRQIN;
  logic [NUM_IRQ-1:0] IRQEN;
  logic               IRQACK;
  logic               IRQOUT;
  logic [ID_W-1:0]    IRQID;
  logic [NUM_IRQ-1:0] IRQPEND;

  modport master (
    input  IRQIN, IRQEN, IRQACK,
    output IRQOUT, IRQID, IRQPEND
  );

  modport slave (
    output IRQIN, IRQEN, IRQACK,
    input  IRQOUT, IRQID, IRQPEND
  );

endinterface

// File: rtl/cmsdk_irq_arb_pick.sv
// Combinational winner search: first set bit of 'eligible' at or after
// start_idx, wrapping modulo NUM_IRQ.
module cmsdk_irq_arb_pick
  import cmsdk_irq_arb_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] eligible,
  input  logic [ID_W-1:0]    start_idx,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  always_comb begin
    int j;
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      j = int'(start_idx) + k;
      if (j >= NUM_IRQ) j = j - NUM_IRQ;
      if (!found && eligible[ID_W'(j)]) begin
        winner = ID_W'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmsdk_irq_sync.sv
// Three-flop synchroniser for one raw IRQ line; the level output is only
// high once two consecutive synchronised samples agree.
module cmsdk_irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[2] & sync_q[1];

endmodule

// File: rtl/cmsdk_irq_arbiter.sv
// Interrupt arbiter: synchronise IRQ lines, latch rising edges as pending, present one winner.
// Define CMSDK_IRQ_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is lowest index wins.
module cmsdk_irq_arbiter
  import cmsdk_irq_arb_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = id_width(NUM_IRQ)
) (
  input  logic                CLK,
  input  logic                RSTn,
  cmsdk_irq_arbiter_if.master bus
);

  localparam int FILL_W = $clog2(SYNC_FILL_CYCLES + 1);

  logic [NUM_IRQ-1:0] level;
  logic [NUM_IRQ-1:0] level_q, level_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_clear;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               fill_done;
  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               irq_out_q, irq_out_d;
  logic [ID_W-1:0]    start_idx;
  logic [ID_W-1:0]    winner;
  logic               found;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    cmsdk_irq_sync u_sync (
      .clk   (CLK),
      .rst_n (RSTn),
      .d     (bus.IRQIN[i]),
      .level (level[i])
    );
  end

  // The edge reference is held high until the synchronisers have refilled after
  // reset, so a line that stayed high through reset needs a fresh low-high transition.
  assign fill_done = (fill_q == FILL_W'(SYNC_FILL_CYCLES));
  assign fill_d    = fill_done ? fill_q : fill_q + FILL_W'(1);
  assign level_d   = fill_done ? level : '1;
  assign rise      = level & ~level_q;
  assign eligible  = pend_q & bus.IRQEN;

`ifdef CMSDK_IRQ_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  assign start_idx = (ptr_q == ID_W'(NUM_IRQ - 1)) ? '0 : ptr_q + ID_W'(1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr_q <= ID_W'(NUM_IRQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start_idx = '0;
`endif

  cmsdk_irq_arb_pick #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_pick (
    .eligible  (eligible),
    .start_idx (start_idx),
    .winner    (winner),
    .found     (found)
  );

  // ACK takes precedence over withdrawal; a fresh edge in the ACK cycle re-sets pend.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ack_clear = '0;
`ifdef CMSDK_IRQ_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = winner;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.IRQACK) begin
          ack_clear[id_q] = 1'b1;
          state_d         = GAP;
`ifdef CMSDK_IRQ_ARB_ROUND_ROBIN_EN
          ptr_d           = id_q;
`endif
        end else if (!bus.IRQEN[id_q]) begin
          state_d = IDLE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    irq_out_d = (state_d == ASSERT);
    pend_d    = (pend_q & ~ack_clear) | rise;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      id_q      <= '0;
      irq_out_q <= 1'b0;
      pend_q    <= '0;
      level_q   <= '1;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      irq_out_q <= irq_out_d;
      pend_q    <= pend_d;
      level_q   <= level_d;
      fill_q    <= fill_d;
    end
  end

  assign bus.IRQOUT  = irq_out_q;
  assign bus.IRQID   = id_q;
  assign bus.IRQPEND = pend_q;

endmodule

// File: tb/tb_cmsdk_irq_arbiter.sv
// Directed self-checking bench for cmsdk_irq_arbiter (NUM_IRQ=8).
// Inputs are driven and outputs sampled 1 time unit after each rising CLK edge.
module tb_cmsdk_irq_arbiter;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

`ifdef CMSDK_IRQ_ARB_ROUND_ROBIN_EN
  localparam logic [ID_W-1:0]    FIRST_ID  = 3'd5;
  localparam logic [ID_W-1:0]    SECOND_ID = 3'd2;
  localparam logic [NUM_IRQ-1:0] LEFT_PEND = 8'h04;
`else
  localparam logic [ID_W-1:0]    FIRST_ID  = 3'd2;
  localparam logic [ID_W-1:0]    SECOND_ID = 3'd5;
  localparam logic [NUM_IRQ-1:0] LEFT_PEND = 8'h20;
`endif

  logic CLK = 1'b0;
  logic RSTn;
  int   error_count = 0;
  int   check_count = 0;

  cmsdk_irq_arbiter_if #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) irq_if ();

  cmsdk_irq_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (irq_if)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkReq(input string tag, input logic out_exp, input logic [ID_W-1:0] id_exp);
    checkOutput({tag, ".IRQOUT"}, 32'(irq_if.IRQOUT), 32'(out_exp));
    if (out_exp) checkOutput({tag, ".IRQID"}, 32'(irq_if.IRQID), 32'(id_exp));
  endtask

  task automatic applyStimulus(input logic [NUM_IRQ-1:0] irq_in, input logic [NUM_IRQ-1:0] irq_en,
                               input logic ack);
    irq_if.IRQIN  = irq_in;
    irq_if.IRQEN  = irq_en;
    irq_if.IRQACK = ack;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulseAck();
    irq_if.IRQACK = 1'b1;
    stepCycles(1);
    irq_if.IRQACK = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RSTn = 1'b0;
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(2);
    checkOutput("reset.IRQOUT", 32'(irq_if.IRQOUT), 32'd0);
    checkOutput("reset.IRQID", 32'(irq_if.IRQID), 32'd0);
    checkOutput("reset.IRQPEND", 32'(irq_if.IRQPEND), 32'h00);
    RSTn = 1'b1;
    stepCycles(4);

    // Single source: pend after N+3, request after N+4, then ACK and gap
    applyStimulus(8'h08, 8'hFF, 1'b0);
    stepCycles(4);
    checkOutput("t1.pend_at_n3", 32'(irq_if.IRQPEND), 32'h08);
    checkReq("t1.at_n3", 1'b0, 3'd0);
    stepCycles(1);
    checkReq("t1.at_n4", 1'b1, 3'd3);
    pulseAck();
    checkReq("t1.after_ack", 1'b0, 3'd0);
    checkOutput("t1.pend_cleared", 32'(irq_if.IRQPEND), 32'h00);
    stepCycles(1);
    checkReq("t1.gap", 1'b0, 3'd0);
    stepCycles(2);
    checkReq("t1.stays_low", 1'b0, 3'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(4);

    // Two simultaneous sources
    applyStimulus(8'h24, 8'hFF, 1'b0);
    stepCycles(4);
    checkOutput("t2.pend_both", 32'(irq_if.IRQPEND), 32'h24);
    stepCycles(1);
    checkReq("t2.first", 1'b1, FIRST_ID);
    pulseAck();
    checkOutput("t2.pend_left", 32'(irq_if.IRQPEND), 32'(LEFT_PEND));
    checkReq("t2.gap", 1'b0, 3'd0);
    stepCycles(1);
    checkReq("t2.idle_m1", 1'b0, 3'd0);
    stepCycles(1);
    checkReq("t2.second", 1'b1, SECOND_ID);
    pulseAck();
    checkOutput("t2.pend_empty", 32'(irq_if.IRQPEND), 32'h00);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(4);

    // Masked source stays pending; stray ACK in IDLE is ignored
    applyStimulus(8'h02, 8'hFD, 1'b0);
    stepCycles(5);
    checkOutput("t3.pend_masked", 32'(irq_if.IRQPEND), 32'h02);
    checkReq("t3.masked", 1'b0, 3'd0);
    pulseAck();
    checkOutput("t3.idle_ack_pend", 32'(irq_if.IRQPEND), 32'h02);
    checkReq("t3.idle_ack", 1'b0, 3'd0);
    applyStimulus(8'h02, 8'hFF, 1'b0);
    stepCycles(1);
    checkReq("t3.enabled", 1'b1, 3'd1);
    pulseAck();
    checkOutput("t3.pend_cleared", 32'(irq_if.IRQPEND), 32'h00);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(4);

    // Withdrawal by disabling the presented source
    applyStimulus(8'h10, 8'hFF, 1'b0);
    stepCycles(5);
    checkReq("t4.asserted", 1'b1, 3'd4);
    applyStimulus(8'h10, 8'hEF, 1'b0);
    stepCycles(1);
    checkReq("t4.withdrawn", 1'b0, 3'd0);
    checkOutput("t4.pend_kept", 32'(irq_if.IRQPEND), 32'h10);
    stepCycles(2);
    checkReq("t4.still_idle", 1'b0, 3'd0);
    applyStimulus(8'h10, 8'hFF, 1'b0);
    stepCycles(1);
    checkReq("t4.reasserted", 1'b1, 3'd4);
    pulseAck();
    checkOutput("t4.pend_cleared", 32'(irq_if.IRQPEND), 32'h00);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(4);

    // New edge on source 0 arriving in the same cycle as its ACK
    applyStimulus(8'h01, 8'hFF, 1'b0);
    stepCycles(5);
    checkReq("t5.asserted", 1'b1, 3'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(2);
    applyStimulus(8'h01, 8'hFF, 1'b0);
    stepCycles(3);
    pulseAck();
    checkReq("t5.after_ack", 1'b0, 3'd0);
    checkOutput("t5.set_wins", 32'(irq_if.IRQPEND), 32'h01);
    stepCycles(1);
    checkReq("t5.gap", 1'b0, 3'd0);
    stepCycles(1);
    checkReq("t5.reasserted", 1'b1, 3'd0);
    pulseAck();
    checkOutput("t5.pend_cleared", 32'(irq_if.IRQPEND), 32'h00);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(4);

    // One-cycle glitch must be filtered
    applyStimulus(8'h40, 8'hFF, 1'b0);
    stepCycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(6);
    checkOutput("t6.glitch_pend", 32'(irq_if.IRQPEND), 32'h00);
    checkReq("t6.glitch_out", 1'b0, 3'd0);

    // Asynchronous reset while asserting; held-high line needs a fresh edge
    applyStimulus(8'h80, 8'hFF, 1'b0);
    stepCycles(5);
    checkReq("t7.asserted", 1'b1, 3'd7);
    #1;
    RSTn = 1'b0;
    #1;
    checkOutput("t7.rst.IRQOUT", 32'(irq_if.IRQOUT), 32'd0);
    checkOutput("t7.rst.IRQID", 32'(irq_if.IRQID), 32'd0);
    checkOutput("t7.rst.IRQPEND", 32'(irq_if.IRQPEND), 32'h00);
    #2;
    RSTn = 1'b1;
    stepCycles(8);
    checkOutput("t7.held_high_pend", 32'(irq_if.IRQPEND), 32'h00);
    checkReq("t7.held_high_out", 1'b0, 3'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(3);
    applyStimulus(8'h80, 8'hFF, 1'b0);
    stepCycles(4);
    checkOutput("t7.new_edge_pend", 32'(irq_if.IRQPEND), 32'h80);
    stepCycles(1);
    checkReq("t7.new_edge_out", 1'b1, 3'd7);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
